// File: rtl/w5100s_spi_slave.sv
// SPI responder for W5100S 32-bit register frames (control, address, data) driving a local
// register bus. Define W5100S_SPISLAVE_STATS_EN to build the frame/error counters.
module w5100s_spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ss_n,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [2:0] {StIdle, StControl, StAddress, StData, StTail} state_e;

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic                   ss_prev, sclk_prev;
    logic                   ss_s, mosi_s;
    logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;

    // Synchronizers run through reset so the pin level is known on release.
    always_ff @(posedge clk) begin
        ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        ss_prev   <= ss_sync[SYNC_STAGES-1];
        sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_fall   = ss_prev & ~ss_s;
    assign ss_rise   = ~ss_prev & ss_s;
    assign sclk_rise = ~sclk_prev & sclk_sync[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev & ~sclk_sync[SYNC_STAGES-1];

    state_e      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [14:0] rx_q, rx_d;
    logic [15:0] rx_shift;
    logic [23:0] tx_q, tx_d;
    logic        miso_q, miso_d;
    logic        miso_oe_q;
    logic        is_wr_q, is_wr_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d, re_q, re_d, done_q, done_d, err_q, err_d;
    logic        rd_pend_q;
    logic        last_rise;

    assign rx_shift  = {rx_q, mosi_s};
    assign last_rise = sclk_rise && (state_q == StData) && (bit_cnt_q == 5'd31);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d   = StControl;
                    bit_cnt_d = '0;
                    // 0x000102 with its MSB already on miso
                    tx_d      = 24'h000204;
                end else if (!ss_s) begin
                    state_d = StTail;
                end
            end
            StControl, StAddress, StData: begin
                if (sclk_fall) begin
                    miso_d = tx_q[23];
                    tx_d   = {tx_q[22:0], 1'b0};
                end
                if (sclk_rise) begin
                    rx_d      = rx_shift[14:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
                if (ss_rise && !last_rise) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                    miso_d  = 1'b0;
                end else if (sclk_rise) begin
                    if (state_q == StControl && bit_cnt_q == 5'd7) begin
                        if (rx_shift[7:0] == 8'hF0 || rx_shift[7:0] == 8'h0F) begin
                            is_wr_d = (rx_shift[7:0] == 8'hF0);
                            state_d = StAddress;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StTail;
                            miso_d  = 1'b0;
                        end
                    end else if (state_q == StAddress && bit_cnt_q == 5'd23) begin
                        addr_d  = rx_shift;
                        state_d = StData;
                        if (is_wr_q) tx_d = {8'h03, 16'h0000};
                        else         re_d = 1'b1;
                    end else if (last_rise) begin
                        if (is_wr_q) begin
                            wdata_d = rx_shift[7:0];
                            we_d    = 1'b1;
                        end
                        done_d  = 1'b1;
                        state_d = ss_rise ? StIdle : StTail;
                        miso_d  = 1'b0;
                    end
                end
            end
            StTail: begin
                miso_d = 1'b0;
                if (ss_rise) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Read data arrives one cycle after the reg_re pulse
        if (rd_pend_q) tx_d[23:16] = reg_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            miso_oe_q <= ~ss_s;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_pend_q <= re_q;
        end
    end

`ifdef W5100S_SPISLAVE_STATS_EN
    logic [15:0] frame_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (done_q && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (err_q && err_cnt_q != 16'hFFFF)    err_cnt_q   <= err_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = wdata_q;
    assign reg_we     = we_q;
    assign reg_re     = re_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_w5100s_spi_slave.sv
// Scoreboard bench for w5100s_spi_slave: stimulus pushes expected bus events, a monitor
// pops and compares them; MISO bytes are compared by the master model.
module tb_w5100s_spi_slave;

    localparam int HALF  = 6;
    localparam int KWE   = 0;
    localparam int KRE   = 1;
    localparam int KDONE = 2;
    localparam int KERR  = 3;

    logic        clk = 1'b0;
    logic        rst, ss_n, sclk, mosi;
    logic        miso, miso_oe, reg_we, reg_re, frame_done, frame_err;
    logic [15:0] reg_addr, frame_cnt, err_cnt;
    logic [7:0]  reg_wdata, reg_rdata;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    assign reg_rdata = (reg_addr == 16'h0038) ? 8'h5C : 8'hEE;

    w5100s_spi_slave #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ss_n      (ss_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    function automatic int stat(input int v);
`ifdef W5100S_SPISLAVE_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] addr, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic [15:0] addr, input logic [7:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h expected none",
                     kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (e.kind == KWE) begin
                chk("we_addr", {16'h0, addr}, {16'h0, e.addr});
                chk("we_data", {24'h0, data}, {24'h0, e.data});
            end
            if (e.kind == KRE) chk("re_addr", {16'h0, addr}, {16'h0, e.addr});
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_we)     pop_check(KWE, reg_addr, reg_wdata);
            if (reg_re)     pop_check(KRE, reg_addr, 8'h00);
            if (frame_done) pop_check(KDONE, 16'h0, 8'h00);
            if (frame_err)  pop_check(KERR, 16'h0, 8'h00);
        end
    end

    task automatic chk_reset();
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_strobes", {reg_we, reg_re, frame_done, frame_err}, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
    endtask

    // Master model: drives on negedge, captures miso at each sclk rise
    task automatic xfer(input logic [31:0] word, input int nbits, input bit start,
                        input bit ss_at_last, output logic [31:0] rx);
        logic [31:0] w;
        w  = word;
        rx = '0;
        if (start) ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        if (start) chk("miso_oe_active", miso_oe, 1);
        for (int i = 0; i < nbits; i++) begin
            mosi = w[31];
            w    = w << 1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            if (ss_at_last && i == nbits - 1) ss_n = 1'b1;
            if (i < 32) rx = {rx[30:0], miso};
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic end_frame(input int gap);
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rx;
        rst  = 1'b1;
        ss_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write frame
        push(KWE, 16'h1234, 8'hA5);
        push(KDONE, 16'h0, 8'h0);
        xfer(32'hF0_1234_A5, 32, 1'b1, 1'b0, rx);
        end_frame(8);
        chk("miso_write", rx, 32'h0001_0203);
        chk("miso_oe_idle", miso_oe, 0);

        // Read frame
        push(KRE, 16'h0038, 8'h0);
        push(KDONE, 16'h0, 8'h0);
        xfer(32'h0F_0038_00, 32, 1'b1, 1'b0, rx);
        end_frame(8);
        chk("miso_read", rx, 32'h0001_025C);
        chk("frame_cnt_2", frame_cnt, stat(2));

        // Truncated write after 20 bits
        push(KERR, 16'h0, 8'h0);
        xfer(32'hF0_5555_66, 20, 1'b1, 1'b0, rx);
        end_frame(8);
        chk("err_cnt_abort", err_cnt, stat(1));

        // Bad opcode, then a valid frame
        push(KERR, 16'h0, 8'h0);
        xfer(32'hAA_1234_55, 32, 1'b1, 1'b0, rx);
        end_frame(8);
        chk("miso_badop", rx, 32'h0);
        push(KWE, 16'h00AB, 8'h77);
        push(KDONE, 16'h0, 8'h0);
        xfer(32'hF0_00AB_77, 32, 1'b1, 1'b0, rx);
        end_frame(8);
        chk("miso_after_bad", rx, 32'h0001_0203);
        chk("frame_cnt_3", frame_cnt, stat(3));
        chk("err_cnt_2", err_cnt, stat(2));

        // Reset at bit 12 with ss_n held low; remaining bits must be ignored
        xfer(32'hF0_2222_33, 12, 1'b1, 1'b0, rx);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset();
        rst = 1'b0;
        xfer(32'h2_2233_000, 20, 1'b0, 1'b0, rx);
        end_frame(8);
        chk("miso_oe_post_rst", miso_oe, 0);
        push(KWE, 16'h00FF, 8'h11);
        push(KDONE, 16'h0, 8'h0);
        xfer(32'hF0_00FF_11, 32, 1'b1, 1'b0, rx);
        end_frame(8);
        chk("miso_post_rst", rx, 32'h0001_0203);

        // Back-to-back frames, 40 sclk pulses, 1 clk ss_n high between them
        push(KWE, 16'h0100, 8'h5A);
        push(KDONE, 16'h0, 8'h0);
        xfer(32'hF0_0100_5A, 40, 1'b1, 1'b0, rx);
        chk("miso_b2b_a", rx, 32'h0001_0203);
        end_frame(1);
        push(KRE, 16'h0038, 8'h0);
        push(KDONE, 16'h0, 8'h0);
        xfer(32'h0F_0038_00, 40, 1'b1, 1'b0, rx);
        end_frame(8);
        chk("miso_b2b_b", rx, 32'h0001_025C);

        // ss_n rise together with the 32nd sclk rise: frame still valid
        push(KWE, 16'h0200, 8'hC3);
        push(KDONE, 16'h0, 8'h0);
        xfer(32'hF0_0200_C3, 32, 1'b1, 1'b1, rx);
        repeat (10) @(negedge clk);
        chk("miso_same_cycle", rx, 32'h0001_0203);

        chk("frame_cnt_final", frame_cnt, stat(4));
        chk("err_cnt_final", err_cnt, stat(0));
        chk("pending_events", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/w5100s_spi_slave.md
# w5100s_spi_slave

SPI responder for the W5100S register-access frame: receives 32-bit frames (control byte, 16-bit address, data byte) from our SPI master and turns them into single-cycle register read/write strobes on a local register bus. Its MISO stream matches the W5100S chip, so the same master logic can drive either. Used as the chip model in board-level loopback and as a slave port on boards where an FPGA stands in for the W5100S.

## Interface
- SYNC_STAGES, 2: synchronizer depth on ss_n/sclk/mosi (legal 2..3).
- clk  input  1  system clock; rising edge only.
- rst  input  1  reset, synchronous, active-high.
- ss_n  input  1  SPI chip select, active-low, asynchronous to clk.
- sclk  input  1  SPI clock, mode 0 (idle low), asynchronous to clk.
- mosi  input  1  SPI data in, MSB first.
- miso  output  1  SPI data out, MSB first.
- miso_oe  output  1  high while ss_n (synchronized) is low; external tristate enable.
- reg_addr  output  16  address of current access.
- reg_wdata  output  8  write data.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read strobe.
- reg_rdata  input  8  read data, sampled exactly 1 clk after reg_re.
- frame_done  output  1  one-cycle pulse, valid frame completed.
- frame_err  output  1  one-cycle pulse, bad opcode or truncated frame.
- frame_cnt  output  16  valid frame count (see Configuration).
- err_cnt  output  16  error count (see Configuration).

## Operation
- Inputs pass through SYNC_STAGES flops; sclk rise/fall and ss_n fall/rise detected from last two synchronized samples.
- mosi sampled on each sclk rise; miso changes on each sclk fall; first bit driven on ss_n fall.
- 5-bit bit counter counts sclk rises since ss_n fall.
- States: IDLE, CONTROL (bits 0-7), ADDRESS (8-23), DATA (24-31), TAIL.
- IDLE: ss_n fall -> CONTROL, counter 0, load miso shifter with 0x000102.
- CONTROL: after 8th rise, byte 0xF0 = write, 0x0F = read -> ADDRESS; any other value -> frame_err pulse, TAIL.
- ADDRESS: after 24th rise reg_addr updated. Read: reg_re pulses that cycle; next cycle reg_rdata loads the shifter; bit 7 goes out on the following sclk fall. Write: shifter loads 0x03.
- DATA: after 32nd rise, for writes reg_wdata updated and reg_we pulses the same cycle. Then frame_done pulses, frame_cnt increments, -> TAIL.
- TAIL: ignore sclk, miso = 0; ss_n rise -> IDLE.
- MISO bytes: control phase 0x00, address phases 0x01, 0x02; data phase rdata (read) or 0x03 (write).
- ss_n rise in CONTROL/ADDRESS/DATA before bit 32: frame_err pulse, no reg_we, -> IDLE. A reg_re already issued stands; it has no side effect.
- More than 32 sclk rises: extras ignored, no further strobes.
- ss_n rise and 32nd sclk rise detected the same cycle: frame is valid; rise handled first, then IDLE.

## Timing
- Reset values: miso 0, miso_oe 0, reg_addr 0, reg_wdata 0, reg_we 0, reg_re 0, frame_done 0, frame_err 0, counters 0, state IDLE.
- Reset mid-frame: after rst release, if synchronized ss_n is low -> TAIL. A partial frame is never decoded.
- Edge-detect latency: SYNC_STAGES+1 clk from pin to internal event.
- sclk high and low each >= SYNC_STAGES+2 clk periods. ss_n fall to first sclk rise >= SYNC_STAGES+2 clk. Our master at 50 MHz meets this with SYNC_STAGES=2.
- reg_we / frame_done: SYNC_STAGES+1 clk after 32nd sclk rise at pin.
- miso is registered, with no combinational path from inputs.

## Configuration
- W5100S_SPISLAVE_STATS_EN defined: frame_cnt counts frame_done pulses and err_cnt counts frame_err pulses. Both 16-bit, saturate at 0xFFFF, clear on rst.
- Undefined: counter logic is not built; frame_cnt and err_cnt are tied to 0. All other behaviour is identical.

## Test plan
- Write frame F0_1234_A5 -> one reg_we with reg_addr 0x1234, reg_wdata 0xA5; frame_done 1 pulse; MISO bytes 00 01 02 03.
- Read frame 0F_0038_xx with reg_rdata 0x5C -> reg_re once with reg_addr 0x0038; MISO bytes 00 01 02 5C; no reg_we.
- Bad opcode 0xAA -> frame_err after 8 bits; no strobes; MISO 0 until ss_n rises; next valid frame accepted.
- ss_n raised after 20 bits of a write -> frame_err pulse, no reg_we, state IDLE. err_cnt = 1 with the macro defined, 0 without.
- rst pulsed at bit 12 with ss_n held low -> all outputs at reset values; remaining clocks ignored. After ss_n rises, the next write frame 00FF = 0x11 produces reg_we.
- Back-to-back frames, minimum 1 clk ss_n high, 40 sclk pulses in one frame -> exactly one strobe per frame. frame_cnt matches the frame count (macro defined).
